// File: rtl/core_types_pkg.sv
// Shared core types for the fetch-stage branch predictor.
// Upper PC Table sizing and the upper-PC type.
package core_types_pkg;

  localparam int UPPER_PC_TABLE_ENTRIES = 8;
  localparam int UPPER_PC_WIDTH = 21;
  localparam int LOG_UPPER_PC_TABLE_ENTRIES =
    $clog2(UPPER_PC_TABLE_ENTRIES);

  typedef logic [UPPER_PC_WIDTH-1:0] upper_PC_t;
  typedef logic [LOG_UPPER_PC_TABLE_ENTRIES-1:0] upct_index_t;

endpackage

// File: rtl/upct_plru.sv
// Tree pseudo-LRU for the Upper PC Table.
// Node bit 0 steers the victim into the left half.
module upct_plru #(
  parameter int ENTRIES = 8,
  localparam int LOG = $clog2(ENTRIES)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           touch_valid,
  input  logic [LOG-1:0] touch_index,
  output logic [LOG-1:0] victim
);

  logic [ENTRIES-2:0] tree;
  logic [ENTRIES-2:0] tree_next;

  always_comb begin
    int node;
    node = 0;
    victim = '0;
    for (int lvl = 0; lvl < LOG; lvl++) begin
      victim[LOG-1-lvl] = tree[node];
      node = 2 * node + 1 + int'(tree[node]);
    end
  end

  // Point every node on the touched path away from the touched entry.
  always_comb begin
    int node;
    logic b;
    node = 0;
    b = 1'b0;
    tree_next = tree;
    for (int lvl = 0; lvl < LOG; lvl++) begin
      b = touch_index[LOG-1-lvl];
      tree_next[node] = ~b;
      node = 2 * node + 1 + int'(b);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tree <= '0;
    end else if (touch_valid) begin
      tree <= tree_next;
    end
  end

endmodule

// File: rtl/upct.sv
// Upper PC Table: CAM encode of upper PCs into BTB indices, indexed decode.
// Define UPCT_WRITE_FORWARD_EN to bypass same-cycle allocations to decode.
module upct
  import core_types_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        read_valid,
  input  upct_index_t read_index,
  output upper_PC_t   read_upper_PC,
  input  logic        update0_valid,
  input  upper_PC_t   update0_upper_PC,
  output upct_index_t update1_upper_PC_index
);

  localparam int N = UPPER_PC_TABLE_ENTRIES;

  upper_PC_t   entry [N];
  logic [N-1:0] valid;

  logic [N-1:0] hit_vec;
  logic         hit;
  upct_index_t  hit_idx;
  logic         any_free;
  upct_index_t  free_idx;
  upct_index_t  victim;
  upct_index_t  alloc_idx;
  upct_index_t  enc_idx;
  logic         write_en;
  upper_PC_t    rd_data;

  always_comb begin
    hit_vec = '0;
    hit_idx = '0;
    for (int i = 0; i < N; i++) begin
      hit_vec[i] = valid[i] && (entry[i] == update0_upper_PC);
      if (hit_vec[i]) hit_idx = upct_index_t'(i);
    end
    hit = |hit_vec;
  end

  // Walk downward so the lowest-numbered invalid entry wins.
  always_comb begin
    any_free = 1'b0;
    free_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        any_free = 1'b1;
        free_idx = upct_index_t'(i);
      end
    end
  end

  upct_plru #(
    .ENTRIES(N)
  ) u_plru (
    .clk        (CLK),
    .rst        (RST),
    .touch_valid(update0_valid),
    .touch_index(enc_idx),
    .victim     (victim)
  );

  always_comb begin
    alloc_idx = any_free ? free_idx : victim;
    enc_idx = hit ? hit_idx : alloc_idx;
    write_en = update0_valid && !hit;
  end

  always_comb begin
    rd_data = entry[read_index];
`ifdef UPCT_WRITE_FORWARD_EN
    if (write_en && (read_index == alloc_idx)) begin
      rd_data = update0_upper_PC;
    end
`endif
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      valid <= '0;
      for (int i = 0; i < N; i++) entry[i] <= '0;
      read_upper_PC <= '0;
      update1_upper_PC_index <= '0;
    end else begin
      if (read_valid) read_upper_PC <= rd_data;
      if (update0_valid) update1_upper_PC_index <= enc_idx;
      if (write_en) begin
        entry[alloc_idx] <= update0_upper_PC;
        valid[alloc_idx] <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_upct.sv
// Self-checking bench for upct against a table/PLRU reference model.
// Honours UPCT_WRITE_FORWARD_EN when computing same-cycle decode results.
module tb_upct;
  import core_types_pkg::*;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        read_valid = 1'b0;
  upct_index_t read_index = '0;
  upper_PC_t   read_upper_PC;
  logic        update0_valid = 1'b0;
  upper_PC_t   update0_upper_PC = '0;
  upct_index_t update1_upper_PC_index;

  int n_checks = 0;
  int n_fail = 0;

  upct dut (
    .CLK                   (CLK),
    .RST                   (RST),
    .read_valid            (read_valid),
    .read_index            (read_index),
    .read_upper_PC         (read_upper_PC),
    .update0_valid         (update0_valid),
    .update0_upper_PC      (update0_upper_PC),
    .update1_upper_PC_index(update1_upper_PC_index)
  );

  always #5 CLK = ~CLK;

  // Model: table contents plus a PLRU kept as one "prefer" bit per
  // subtree, keyed by tree level and index prefix.
  int  m_ent [8];
  bit  m_vld [8];
  bit  m_pref [3][8];
  int  exp_rd = 0;
  int  exp_idx = 0;

  function automatic int m_victim();
    int p = 0;
    for (int l = 0; l < 3; l++) p = p * 2 + int'(m_pref[l][p]);
    return p;
  endfunction

  function automatic void m_touch(int idx);
    for (int l = 0; l < 3; l++) begin
      m_pref[l][idx >> (3 - l)] = !((idx >> (2 - l)) & 1);
    end
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 8; i++) begin
      m_ent[i] = 0;
      m_vld[i] = 0;
      for (int l = 0; l < 3; l++) m_pref[l][i] = 0;
    end
    exp_rd = 0;
    exp_idx = 0;
  endfunction

  // Apply one cycle of stimulus, advance the model, sample after the edge.
  task automatic cyc(bit rst, bit rv, int ri, bit uv, int pc);
    int found = -1;
    int slot = -1;
    RST = rst;
    read_valid = rv;
    read_index = upct_index_t'(ri);
    update0_valid = uv;
    update0_upper_PC = upper_PC_t'(pc);
    if (rst) begin
      m_reset();
    end else begin
      if (uv) begin
        for (int i = 0; i < 8; i++)
          if (m_vld[i] && m_ent[i] == pc) found = i;
        if (found < 0) begin
          for (int i = 7; i >= 0; i--) if (!m_vld[i]) slot = i;
          if (slot < 0) slot = m_victim();
        end
      end
      if (rv) begin
        exp_rd = m_ent[ri];
`ifdef UPCT_WRITE_FORWARD_EN
        if (slot == ri) exp_rd = pc;
`endif
      end
      if (uv) begin
        exp_idx = (found >= 0) ? found : slot;
        m_touch(exp_idx);
        if (slot >= 0) begin
          m_ent[slot] = pc;
          m_vld[slot] = 1;
        end
      end
    end
    @(posedge CLK);
    #1;
    RST = 1'b0;
    read_valid = 1'b0;
    update0_valid = 1'b0;
  endtask

  task automatic test_reset();
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    n_checks++;
    if (read_upper_PC !== '0 || update1_upper_PC_index !== '0) begin
      n_fail++;
      $display("FAIL reset: rd=%h idx=%0d want 0/0",
               read_upper_PC, update1_upper_PC_index);
    end
  endtask

  task automatic test_first_encode();
    cyc(0, 0, 0, 1, 'h1ABCD);
    n_checks++;
    if (update1_upper_PC_index !== 3'd0) begin
      n_fail++;
      $display("FAIL first_enc: idx=%0d want 0", update1_upper_PC_index);
    end
    cyc(0, 1, 0, 0, 0);
    n_checks++;
    if (read_upper_PC !== 21'h1ABCD) begin
      n_fail++;
      $display("FAIL first_dec: rd=%h want 1abcd", read_upper_PC);
    end
  endtask

  task automatic test_fill_and_hit();
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 0, 1, 'h100 + i);
      n_checks++;
      if (update1_upper_PC_index !== upct_index_t'(i)) begin
        n_fail++;
        $display("FAIL fill: idx=%0d want %0d", update1_upper_PC_index, i);
      end
    end
    cyc(0, 0, 0, 1, 'h103);
    n_checks++;
    if (update1_upper_PC_index !== 3'd3) begin
      n_fail++;
      $display("FAIL rehit: idx=%0d want 3", update1_upper_PC_index);
    end
    for (int i = 0; i < 8; i++) begin
      cyc(0, 1, i, 0, 0);
      n_checks++;
      if (read_upper_PC !== upper_PC_t'('h100 + i)) begin
        n_fail++;
        $display("FAIL fill_dec%0d: rd=%h want %h",
                 i, read_upper_PC, 'h100 + i);
      end
    end
  endtask

  task automatic test_full_victim();
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1, 'h100 + i);
    cyc(0, 0, 0, 1, 'h1FFFF);
    n_checks++;
    if (update1_upper_PC_index !== 3'd0 || exp_idx != 0) begin
      n_fail++;
      $display("FAIL victim: idx=%0d want 0", update1_upper_PC_index);
    end
    cyc(0, 1, 0, 0, 0);
    n_checks++;
    if (read_upper_PC !== 21'h1FFFF) begin
      n_fail++;
      $display("FAIL victim_dec: rd=%h want 1ffff", read_upper_PC);
    end
  endtask

  task automatic test_back_to_back();
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 'h00042);
    n_checks++;
    if (update1_upper_PC_index !== 3'd0) begin
      n_fail++;
      $display("FAIL b2b_1: idx=%0d want 0", update1_upper_PC_index);
    end
    cyc(0, 0, 0, 1, 'h00042);
    n_checks++;
    if (update1_upper_PC_index !== 3'd0) begin
      n_fail++;
      $display("FAIL b2b_2: idx=%0d want 0", update1_upper_PC_index);
    end
    // A single valid bit means the next new PC lands in entry 1.
    cyc(0, 0, 0, 1, 'h00043);
    n_checks++;
    if (update1_upper_PC_index !== 3'd1) begin
      n_fail++;
      $display("FAIL b2b_next: idx=%0d want 1", update1_upper_PC_index);
    end
  endtask

  task automatic test_same_cycle();
    int want_old;
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 'h0AAAA);
    cyc(0, 0, 0, 1, 'h0BBBB);
    cyc(0, 1, 2, 1, 'h12345);
`ifdef UPCT_WRITE_FORWARD_EN
    want_old = 'h12345;
`else
    want_old = 0;
`endif
    n_checks++;
    if (read_upper_PC !== upper_PC_t'(want_old)
        || update1_upper_PC_index !== 3'd2) begin
      n_fail++;
      $display("FAIL same_cyc: rd=%h idx=%0d want %h/2",
               read_upper_PC, update1_upper_PC_index, want_old);
    end
    cyc(0, 1, 2, 0, 0);
    n_checks++;
    if (read_upper_PC !== 21'h12345) begin
      n_fail++;
      $display("FAIL same_next: rd=%h want 12345", read_upper_PC);
    end
  endtask

  task automatic test_reset_mid();
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 1, 'h700 + i);
    cyc(0, 1, 3, 0, 0);
    cyc(1, 1, 3, 1, 'h999);
    n_checks++;
    if (read_upper_PC !== '0 || update1_upper_PC_index !== '0) begin
      n_fail++;
      $display("FAIL rst_mid: rd=%h idx=%0d want 0/0",
               read_upper_PC, update1_upper_PC_index);
    end
    cyc(0, 1, 3, 0, 0);
    n_checks++;
    if (read_upper_PC !== '0) begin
      n_fail++;
      $display("FAIL rst_clear: rd=%h want 0", read_upper_PC);
    end
    cyc(0, 0, 0, 1, 'h555);
    n_checks++;
    if (update1_upper_PC_index !== 3'd0) begin
      n_fail++;
      $display("FAIL rst_enc: idx=%0d want 0", update1_upper_PC_index);
    end
  endtask

  task automatic test_random();
    cyc(1, 0, 0, 0, 0);
    for (int k = 0; k < 400; k++) begin
      cyc(0, $urandom_range(1, 0), $urandom_range(7, 0),
          $urandom_range(3, 0) != 0, 'h40000 + $urandom_range(13, 0));
      n_checks++;
      if (read_upper_PC !== upper_PC_t'(exp_rd)
          || update1_upper_PC_index !== upct_index_t'(exp_idx)) begin
        n_fail++;
        $display("FAIL rand%0d: rd=%h idx=%0d want %h/%0d",
                 k, read_upper_PC, update1_upper_PC_index, exp_rd, exp_idx);
      end
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_first_encode();
    test_fill_and_hit();
    test_full_victim();
    test_back_to_back();
    test_same_cycle();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
